uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter Data_Len, default 8: number of data bits per frame, sent LSB first.
REQ-002 Parameter OVS, default 8: oversampling ratio, CLK cycles per bit; legal values 8, 16 and 32.
REQ-003 CLK  input  1  single clock; all logic on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 RX_IN  input  1  serial line; idles high; asynchronous to CLK.
REQ-006 PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 PAR_TYP  input  1  1 = odd-type parity, 0 = even-type parity; same encoding as the team's transmitter.
REQ-008 P_DATA  output  Data_Len  received data word; held until the next accepted frame.
REQ-009 Data_Valid  output  1  one-cycle pulse when P_DATA holds a new error-free frame.
REQ-010 par_err  output  1  one-cycle pulse on a parity mismatch.
REQ-011 stp_err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-012 RX_IN SHALL pass through a 2-flop synchronizer; all further references to RX_IN mean the synchronized value.
REQ-013 States SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-014 Counters:
- edge_cnt counts 0..OVS-1 within each bit and wraps to 0.
- bit_cnt counts 0..Data_Len-1 in DATA.
REQ-015 Each bit value SHALL be the majority vote of the samples at edge_cnt = OVS/2-1, OVS/2 and OVS/2+1.
- The vote result is valid at edge_cnt = OVS/2+2.
REQ-016 IDLE: when RX_IN = 0 at a CLK edge, the FSM SHALL go to START with edge_cnt = 0.
REQ-017 START: if the voted start bit is 1 (glitch), the FSM SHALL return to IDLE with no output pulse.
- Otherwise it SHALL go to DATA at edge_cnt wrap.
REQ-018 DATA: each voted bit SHALL be shifted into bit position bit_cnt.
- After bit Data_Len-1 at edge_cnt wrap, the FSM goes to PARITY if PAR_EN = 1, else to STOP.
REQ-019 Expected parity SHALL be ^data when PAR_TYP = 1 and ~^data when PAR_TYP = 0.
- This exactly matches the transmitter's par_bit.
REQ-020 PARITY: the voted parity bit SHALL be compared with the expected value.
- A mismatch is latched as a pending parity error.
- The FSM goes to STOP at edge_cnt wrap.
REQ-021 STOP: at vote-valid (edge_cnt = OVS/2+2), the FSM SHALL evaluate the frame and go to IDLE in the same cycle.
- It SHALL NOT wait for the rest of the stop bit, so a start edge in the next cycle is accepted.
REQ-022 Frame evaluation, with all pulses asserted in the cycle after evaluation:
- Stop bit 0 -> stp_err pulse.
- Pending parity error -> par_err pulse.
- Both conditions -> both pulses in the same cycle.
- Neither condition -> P_DATA updated and Data_Valid pulse.
REQ-023 P_DATA SHALL change only together with a Data_Valid pulse; erroneous frames SHALL NOT update it.
REQ-024 PAR_EN and PAR_TYP SHALL be sampled at the IDLE->START transition and held for the whole frame.
REQ-025 Latency: with PAR_EN = 1 and OVS = 8, Data_Valid SHALL rise (Data_Len+2)*8 + 7 cycles after the first synchronized low sample; with PAR_EN = 0, subtract 8 cycles.
REQ-026 RX_IN transitions inside a bit SHALL NOT affect timing; only the IDLE start edge resynchronizes edge_cnt.

Reset
REQ-027 On RST high, without waiting for CLK:
- FSM = IDLE; edge_cnt, bit_cnt and pending errors = 0.
- P_DATA = 0; Data_Valid, par_err and stp_err = 0.
- Synchronizer flops = 1.
REQ-028 Reset mid-frame SHALL discard the partial frame.
- After RST release, the first frame is accepted only from a fresh start edge.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state enumeration, the default Data_Len, the default OVS, and the parity-type encoding constants.
- Both the TX and RX blocks use this package.
REQ-030 One sub-module, data_sampling, SHALL implement the three-sample majority vote and the vote-valid strobe.
- Its ports are CLK, RST, the synchronized RX_IN, edge_cnt and sample-enable.

Verification (Data_Len = 8, OVS = 8)
REQ-031 Frame 0xA5, PAR_EN = 1, PAR_TYP = 0, parity bit 1, stop bit 1 -> P_DATA = 0xA5 and a single Data_Valid pulse; no error pulses.
REQ-032 Same frame with parity bit 0 -> par_err pulse; no Data_Valid; P_DATA keeps its previous value.
REQ-033 Frame 0x3C, PAR_EN = 0, stop bit 0 -> stp_err pulse; no Data_Valid.
REQ-034 RX_IN low for 2 cycles from idle -> FSM back in IDLE; no pulses; a following valid frame 0x55 -> Data_Valid, P_DATA = 0x55.
REQ-035 Back-to-back frames 0x01 and 0xFE (PAR_EN = 1, PAR_TYP = 1, parity bits 1 and 1), next start bit immediately after the stop bit -> two Data_Valid pulses, P_DATA = 0x01 then 0xFE.
REQ-036 RST asserted during DATA bit 3, then a valid frame 0x81 -> all outputs 0 at once; no pulse for the aborted frame; Data_Valid with P_DATA = 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame state encoding,
// default frame geometry, parity-type encoding and small bit-level helpers.
package uart_pkg;

  localparam int DEF_DATA_LEN = 8;
  localparam int DEF_OVS      = 8;

  // PAR_TYP encoding, identical on the TX and RX sides.
  localparam logic PAR_TYP_EVEN = 1'b0;
  localparam logic PAR_TYP_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit from the XOR-reduction of the data word; this mirrors the
  // transmitter's par_bit, so "odd" selects the plain XOR of the data.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_TYP_ODD) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Three-sample majority vote around the middle of each bit period; the voted bit
// and its one-cycle strobe are registered so both are valid at edge_cnt = OVS/2+2.
module data_sampling
  import uart_pkg::*;
#(
  parameter int OVS = DEF_OVS,
  parameter int EW  = $clog2(OVS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          rx_sync,
  input  logic [EW-1:0] edge_cnt,
  input  logic          sample_en,
  output logic          sampled_bit,
  output logic          vote_valid
);

  localparam logic [EW-1:0] SMP_FIRST = EW'(OVS / 2 - 1);
  localparam logic [EW-1:0] SMP_MID   = EW'(OVS / 2);
  localparam logic [EW-1:0] SMP_LAST  = EW'(OVS / 2 + 1);

  logic [1:0] early_smp;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      early_smp   <= 2'b11;
      sampled_bit <= 1'b1;
      vote_valid  <= 1'b0;
    end else begin
      vote_valid <= 1'b0;
      if (sample_en) begin
        if (edge_cnt == SMP_FIRST) early_smp[0] <= rx_sync;
        if (edge_cnt == SMP_MID)   early_smp[1] <= rx_sync;
        // The third sample is taken live, so the vote lands one cycle later.
        if (edge_cnt == SMP_LAST) begin
          sampled_bit <= majority3(early_smp[0], early_smp[1], rx_sync);
          vote_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized line, oversampled start detection, voted data bits,
// optional parity and an early stop-bit decision that frees the line for the next frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Data_Len = DEF_DATA_LEN,
  parameter int OVS      = DEF_OVS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  output logic [Data_Len-1:0] P_DATA,
  output logic                Data_Valid,
  output logic                par_err,
  output logic                stp_err,
  output uart_state_e         dbg_state
);

  // Output protocol: Data_Valid, par_err and stp_err are single-cycle pulses with no
  // back-pressure; P_DATA changes only in the cycle Data_Valid is high and holds otherwise.

  localparam int EW = $clog2(OVS);
  localparam int BW = (Data_Len > 1) ? $clog2(Data_Len) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(Data_Len - 1);

  logic                rx_meta;
  logic                rx_sync;
  logic [1:0]          flush;
  logic                armed;
  uart_state_e         state;
  logic [EW-1:0]       edge_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [Data_Len-1:0] shift_reg;
  logic                par_en_q;
  logic                par_typ_q;
  logic                par_pend;
  logic                sampled_bit;
  logic                vote_valid;
  logic                edge_wrap;
  logic                sample_en;

  assign edge_wrap = (edge_cnt == EDGE_LAST);
  assign sample_en = (state != IDLE);
  assign dbg_state = state;

  // Start detection is held off until the synchronizer has flushed its reset value
  // and the real line has been seen high, so a line already low at reset release
  // is not mistaken for a start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      flush   <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= RX_IN;
      rx_sync <= rx_meta;
      flush   <= {flush[0], 1'b1};
      if (flush[1] && rx_sync) armed <= 1'b1;
    end
  end

  data_sampling #(
    .OVS (OVS),
    .EW  (EW)
  ) u_sampling (
    .CLK         (CLK),
    .RST         (RST),
    .rx_sync     (rx_sync),
    .edge_cnt    (edge_cnt),
    .sample_en   (sample_en),
    .sampled_bit (sampled_bit),
    .vote_valid  (vote_valid)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_pend   <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state != IDLE) edge_cnt <= edge_wrap ? '0 : edge_cnt + EW'(1);

      case (state)
        IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          par_pend <= 1'b0;
          if (armed && !rx_sync) begin
            state     <= START;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
          end
        end

        START: begin
          if (vote_valid && sampled_bit) state <= IDLE;
          else if (edge_wrap)            state <= DATA;
        end

        DATA: begin
          if (vote_valid) shift_reg[bit_cnt] <= sampled_bit;
          if (edge_wrap) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        PARITY: begin
          if (vote_valid) par_pend <= (sampled_bit != parity_bit(^shift_reg, par_typ_q));
          if (edge_wrap)  state    <= STOP;
        end

        // Decide at vote-valid and return to IDLE at once so a start bit that
        // follows the stop bit's centre is not missed.
        STOP: begin
          if (vote_valid) begin
            state   <= IDLE;
            stp_err <= ~sampled_bit;
            par_err <= par_pend;
            if (sampled_bit && !par_pend) begin
              P_DATA     <= shift_reg;
              Data_Valid <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (Data_Len = 8, OVS = 8): hand-built frames driven on the
// falling clock edge, outputs checked with immediate assertions.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DL  = 8;
  localparam int OVS = 8;

  logic          CLK     = 1'b0;
  logic          RST     = 1'b1;
  logic          RX_IN   = 1'b1;
  logic          PAR_EN  = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DL-1:0] P_DATA;
  logic          Data_Valid;
  logic          par_err;
  logic          stp_err;
  uart_state_e   dbg_state;

  uart_rx #(
    .Data_Len (DL),
    .OVS      (OVS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int errors    = 0;
  int checks    = 0;
  int dv_cnt    = 0;
  int pe_cnt    = 0;
  int se_cnt    = 0;
  int both_cnt  = 0;
  int dv_cyc    = 0;
  int start_cyc = 0;
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] prev_pdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / pulse monitor ----------------
  always @(negedge CLK) begin
    logic [DL-1:0] e;
    if (Data_Valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_dv: observed P_DATA=%0h expected no frame", P_DATA);
      end else begin
        e = exp_q.pop_front();
        assert (P_DATA === e)
        else begin
          errors++;
          $error("FAIL sb_pdata: observed=%0h expected=%0h", P_DATA, e);
        end
      end
    end
    if (par_err) pe_cnt++;
    if (stp_err) se_cnt++;
    if (par_err && stp_err) both_cnt++;
    if (!RST && (P_DATA !== prev_pdata)) begin
      checks++;
      assert (Data_Valid === 1'b1)
      else begin
        errors++;
        $error("FAIL pdata_hold: observed P_DATA %0h->%0h with Data_Valid=%0b expected 1",
               prev_pdata, P_DATA, Data_Valid);
      end
    end
    prev_pdata = P_DATA;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    RX_IN = b;
    repeat (OVS) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // flip_cfg toggles PAR_EN/PAR_TYP once the frame is under way; the receiver
  // must keep the values it latched at the start edge.
  task automatic send_frame(input logic [DL-1:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input logic flip_cfg);
    PAR_EN    = pen;
    PAR_TYP   = ptyp;
    start_cyc = cyc;
    send_bit(1'b0);
    if (flip_cfg) begin
      PAR_EN  = ~pen;
      PAR_TYP = ~ptyp;
    end
    for (int i = 0; i < DL; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(sbit);
    PAR_EN  = pen;
    PAR_TYP = ptyp;
  endtask

  // Latency from the driven start edge: 2 synchronizer flops + 1 detect cycle
  // + (Data_Len+2)*8+7 = 90 with parity, 82 without.
  localparam int LAT_PAR   = 90;
  localparam int LAT_NOPAR = 82;

  // ---------------- directed sequence ----------------
  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_dv", Data_Valid, 1'b0);
    chk("rst_par_err", par_err, 1'b0);
    chk("rst_stp_err", stp_err, 1'b0);
    chk("rst_state", dbg_state, IDLE);

    RST = 1'b0;
    idle(6);

    // Good frame 0xA5, even-type parity bit 1.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(8);
    chk("a5_dv_count", dv_cnt, 1);
    chk("a5_pdata", P_DATA, 8'hA5);
    chk("a5_no_err", pe_cnt + se_cnt, 0);
    chk("a5_latency", dv_cyc - start_cyc, LAT_PAR);

    // Same frame with a wrong parity bit.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    chk("par_err_count", pe_cnt, 1);
    chk("par_no_dv", dv_cnt, 1);
    chk("par_no_stp", se_cnt, 0);
    chk("par_pdata_kept", P_DATA, 8'hA5);

    // 0x3C without parity, stop bit low.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("stp_err_count", se_cnt, 1);
    chk("stp_no_dv", dv_cnt, 1);
    chk("stp_no_par", pe_cnt, 1);
    chk("stp_pdata_kept", P_DATA, 8'hA5);

    // Wrong parity and low stop bit together.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("both_same_cycle", both_cnt, 1);
    chk("both_par_count", pe_cnt, 2);
    chk("both_stp_count", se_cnt, 2);
    chk("both_no_dv", dv_cnt, 1);

    // Two-cycle glitch from idle, then a good 0x55 without parity.
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(16);
    chk("glitch_state", dbg_state, IDLE);
    chk("glitch_no_dv", dv_cnt, 1);
    chk("glitch_no_err", pe_cnt + se_cnt, 4);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    chk("x55_dv_count", dv_cnt, 2);
    chk("x55_pdata", P_DATA, 8'h55);
    chk("x55_latency", dv_cyc - start_cyc, LAT_NOPAR);

    // Back-to-back 0x01 and 0xFE, odd-type parity, both parity bits 1.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFE);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(8);
    chk("b2b_dv_count", dv_cnt, 4);
    chk("b2b_pdata", P_DATA, 8'hFE);
    chk("b2b_no_err", pe_cnt + se_cnt, 4);
    chk("b2b_latency", dv_cyc - start_cyc, LAT_PAR);

    // Reset in the middle of data bit 3 of 0x81.
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre_rst_state", dbg_state, DATA);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_pdata", P_DATA, 8'h00);
    chk("async_rst_dv", Data_Valid, 1'b0);
    chk("async_rst_errs", {par_err, stp_err}, 2'b00);
    chk("async_rst_state", dbg_state, IDLE);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    // Line is still low at release (rest of the aborted frame), so no start edge.
    repeat (20) @(negedge CLK);
    idle(24);
    chk("abort_no_dv", dv_cnt, 4);
    chk("abort_no_err", pe_cnt + se_cnt, 4);
    chk("abort_pdata", P_DATA, 8'h00);

    // Fresh 0x81, even-type parity bit 1, config inputs toggled mid-frame.
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(8);
    chk("x81_dv_count", dv_cnt, 5);
    chk("x81_pdata", P_DATA, 8'h81);
    chk("x81_no_err", pe_cnt + se_cnt, 4);
    chk("x81_latency", dv_cyc - start_cyc, LAT_PAR);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
